mem_arbiter: RTL and testbench

Memory controller arbitration stage sitting directly below the instruction and data caches: consumes the icache/dcache request signals (iREN, iaddr, dREN, dWEN, daddr, dstore) and returns iwait/iload and dwait/dload. Serialises both requesters onto a single RAM port using a registered grant state machine. Data requests take priority, with a bounded-starvation counter guaranteeing instruction fetch progress. One transaction in flight at a time; every RAM access is completed or aborted before the next grant.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitration stage between the icache/dcache and a single RAM port.
// Data requests win, except that a starvation counter forces an instruction grant.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {StIdle, StIgnt, StDgnt} state_e;

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [3:0] Limit     = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       d_req;

    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (d_req && !(iREN && starve_q == Limit)) begin
                    state_d = StDgnt;
                end else if (iREN) begin
                    state_d = StIgnt;
                end
            end

            StIgnt: begin
                if (!iREN) begin
                    state_d = StIdle;  // abort: strobes stay low, counter untouched
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == RamAccess) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        state_d  = StIdle;
                        starve_d = 4'd0;
                    end
                end
            end

            StDgnt: begin
                if (!d_req) begin
                    state_d = StIdle;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RamAccess) begin
                        dwait   = 1'b0;
                        dload   = dWEN ? 32'd0 : ramload;
                        state_d = StIdle;
                        if (!iREN) begin
                            starve_d = 4'd0;
                        end else if (starve_q < Limit) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when driven
// and checked in order as each requester sees its wait drop.
module tb_mem_arbiter;

    localparam logic [31:0] LoadKey = 32'hA5A5_0000;
    localparam logic [1:0]  Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        use_fixed;
    logic [31:0] fixed_load;

    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // RAM model: read data is a function of the address unless a fixed word is forced
    assign ramload = use_fixed ? fixed_load : (ramaddr ^ LoadKey);

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h44; daddr = 32'h100; dstore = 32'h0;
        ramstate = Free; use_fixed = 1'b0; fixed_load = 32'h0;
        #12;
        n_checks++;
        if (iwait !== 1'b1 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL reset_wait got i=%b d=%b want 1 1", iwait, dwait);
        end
        n_checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ram got ren=%b wen=%b addr=%h want 0 0 0", ramREN, ramWEN, ramaddr);
        end
        tick();
        nRST = 1'b1;
        #3;
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle got ramREN=%b want 0", ramREN);
        end
        tick(); #3;
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 1'b1 || iwait !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dgnt got ren=%b addr=%h dwait=%b iwait=%b want 1 100 1 1",
                     ramREN, ramaddr, dwait, iwait);
        end
        tick();
        iREN = 1'b0; dREN = 1'b0;
        #3;
        n_checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL reset_abort got ren=%b dwait=%b want 0 1", ramREN, dwait);
        end
        tick();
    endtask

    task automatic test_single_iread();
        txn_t t;
        iREN = 1'b1; iaddr = 32'h40; ramstate = Free;
        use_fixed = 1'b1; fixed_load = 32'hDEAD_BEEF;
        sb.push_back('{is_d: 1'b0, is_wr: 1'b0, addr: 32'h40, data: 32'hDEAD_BEEF});
        #3;
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL iread_idle got ramREN=%b want 0", ramREN);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            ramstate = (c < 2) ? Busy : Access;
            #3;
            n_checks++;
            if (ramaddr !== 32'h40 || ramREN !== 1'b1 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
                n_fail++;
                $display("FAIL iread_strobe c%0d got addr=%h ren=%b wen=%b dwait=%b want 40 1 0 1",
                         c, ramaddr, ramREN, ramWEN, dwait);
            end
            n_checks++;
            if (iwait !== ((c < 2) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL iread_wait c%0d got iwait=%b", c, iwait);
            end
            if (!iwait && sb.size() > 0) begin
                t = sb.pop_front();
                n_checks++;
                if (iload !== t.data || ramaddr !== t.addr) begin
                    n_fail++;
                    $display("FAIL iread_data got load=%h addr=%h want %h %h",
                             iload, ramaddr, t.data, t.addr);
                end
            end
        end
        tick();
        iREN = 1'b0; ramstate = Free; use_fixed = 1'b0;
        #3;
        n_checks++;
        if (ramREN !== 1'b0 || sb.size() != 0) begin
            n_fail++; $display("FAIL iread_end got ren=%b pending=%0d want 0 0", ramREN, sb.size());
        end
        tick();
    endtask

    // Generic run: ACCESS on every strobed cycle, completions popped from the scoreboard.
    task automatic run_scoreboard(input string name, input int budget, input bit drop_when_empty,
                                  output int done_cyc[$]);
        txn_t t;
        int   cyc = 0;
        done_cyc.delete();
        while (sb.size() > 0 && cyc < budget) begin
            #3;
            if (!dwait || !iwait) begin
                done_cyc.push_back(cyc);
                t = sb.pop_front();
                n_checks++;
                if (t.is_d !== !dwait) begin
                    n_fail++; $display("FAIL %s_order got d=%b want d=%b", name, !dwait, t.is_d);
                end else begin
                    n_checks++;
                    if (ramaddr !== t.addr || (t.is_wr && (ramstore !== t.data || ramWEN !== 1'b1 ||
                        ramREN !== 1'b0)) || (!t.is_wr && t.is_d && dload !== t.data) ||
                        (!t.is_d && iload !== t.data)) begin
                        n_fail++;
                        $display("FAIL %s_data got addr=%h store=%h dload=%h iload=%h want %h %h",
                                 name, ramaddr, ramstore, dload, iload, t.addr, t.data);
                    end
                end
                tick();
                if (t.is_d && t.is_wr) dWEN = 1'b0;
                if (!t.is_d && drop_when_empty && sb.size() == 0) iREN = 1'b0;
                if (drop_when_empty && sb.size() == 0) begin dREN = 1'b0; iREN = 1'b0; end
            end else begin
                tick();
            end
            cyc++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_contention();
        int dc[$];
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; dREN = 1'b0;
        daddr = 32'h80; dstore = 32'h1234; ramstate = Access;
        sb.push_back('{is_d: 1'b1, is_wr: 1'b1, addr: 32'h80, data: 32'h1234});
        sb.push_back('{is_d: 1'b0, is_wr: 1'b0, addr: 32'h44, data: 32'h44 ^ LoadKey});
        run_scoreboard("contention", 12, 1'b1, dc);
        n_checks++;
        if (dc.size() != 2 || dc[0] != 1 || dc[1] != 3) begin
            n_fail++;
            $display("FAIL contention_timing got n=%0d first=%0d second=%0d want 2 1 3",
                     dc.size(), (dc.size() > 0) ? dc[0] : -1, (dc.size() > 1) ? dc[1] : -1);
        end
        tick();
    endtask

    task automatic test_starvation();
        int dc[$];
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h200;
        ramstate = Access;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) sb.push_back('{is_d: 1'b0, is_wr: 1'b0, addr: 32'h300, data: 32'h300 ^ LoadKey});
            else        sb.push_back('{is_d: 1'b1, is_wr: 1'b0, addr: 32'h200, data: 32'h200 ^ LoadKey});
        end
        run_scoreboard("starve", 40, 1'b1, dc);
        n_checks++;
        if (dc.size() != 6 || dc[4] != 9 || dc[5] != 11) begin
            n_fail++;
            $display("FAIL starve_timing got n=%0d i_cyc=%0d last=%0d want 6 9 11",
                     dc.size(), (dc.size() > 4) ? dc[4] : -1, (dc.size() > 5) ? dc[5] : -1);
        end
        // Last D completion had iREN high, so the counter restarted from 0 to 1.
        #3;
        n_checks++;
        if (dut.starve_q !== 4'd1) begin
            n_fail++; $display("FAIL starve_counter got %0d want 1", dut.starve_q);
        end
        tick();
    endtask

    task automatic test_abort_error();
        iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h500; ramstate = Error;
        for (int c = 0; c < 3; c++) begin
            tick(); #3;
            n_checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h500 || dwait !== 1'b1) begin
                n_fail++;
                $display("FAIL error_hold c%0d got ren=%b addr=%h dwait=%b want 1 500 1",
                         c, ramREN, ramaddr, dwait);
            end
        end
        tick();
        dREN = 1'b0;
        #3;
        n_checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            n_fail++; $display("FAIL abort_strobe got ren=%b dwait=%b want 0 1", ramREN, dwait);
        end
        tick(); #3;
        n_checks++;
        if (dut.state_q !== 2'd0 || dut.starve_q !== 4'd1) begin
            n_fail++;
            $display("FAIL abort_state got state=%0d starve=%0d want 0 1", dut.state_q, dut.starve_q);
        end
        tick();
    endtask

    task automatic test_rw_async_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFE; ramstate = Busy;
        tick(); #3;
        n_checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hCAFE || dwait !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_both got wen=%b ren=%b store=%h dwait=%b want 1 0 cafe 1",
                     ramWEN, ramREN, ramstore, dwait);
        end
        tick();
        #1;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1 ||
            dload !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got wen=%b ren=%b addr=%h dwait=%b want 0 0 0 1",
                     ramWEN, ramREN, ramaddr, dwait);
        end
        n_checks++;
        if (dut.starve_q !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_counter got %0d want 0", dut.starve_q);
        end
        dREN = 1'b0; dWEN = 1'b0; ramstate = Free;
        tick();
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_iread();
        test_contention();
        test_starvation();
        test_abort_error();
        test_rw_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
